soc_state_dumper: RTL

//  Hardware end-of-program detector and state reader for the SoC. Counts run cycles, detects the

---
 rtl/soc_state_dumper.sv | 166 ++++++++++++++++
 1 files changed

// File: rtl/soc_state_dumper.sv
// End-of-program detector and state reader: counts run cycles, spots the halt fetch,
// drains the pipeline, then streams DMEM words and RF entries out over valid/ready.
module soc_state_dumper #(
  parameter int unsigned DMEM_DUMP_WORDS = 20,
  parameter int unsigned RF_DUMP_REGS    = 32,
  parameter int unsigned DRAIN_CYCLES    = 5,
  parameter int unsigned TIMEOUT_CYCLES  = 1000000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] inst_from_imem,
  output logic        halt_req,
  output logic [31:0] dmem_rd_addr,
  input  logic [31:0] dmem_rd_data,
  output logic [4:0]  rf_rd_addr,
  input  logic [31:0] rf_rd_data,
  output logic        dump_valid,
  input  logic        dump_ready,
  output logic        dump_src,
  output logic [5:0]  dump_index,
  output logic [31:0] dump_data,
  output logic [31:0] cycle_count,
  output logic        timed_out,
  output logic        done
);

  localparam int unsigned DATA_W  = 32;
  localparam int unsigned IDX_W   = 6;
  localparam int unsigned RF_AW   = 5;
  localparam int unsigned DRAIN_W = $clog2(DRAIN_CYCLES + 2);

  localparam logic [IDX_W-1:0]   DMEM_LAST = IDX_W'(DMEM_DUMP_WORDS - 1);
  localparam logic [IDX_W-1:0]   RF_LAST   = IDX_W'(RF_DUMP_REGS - 1);
  localparam logic [DATA_W:0]    TIMEOUT_X = (DATA_W + 1)'(TIMEOUT_CYCLES);
  localparam logic [DRAIN_W-1:0] DRAIN_LD  = DRAIN_W'(DRAIN_CYCLES);

  typedef enum logic [2:0] {
    S_RUN, S_DRAIN, S_RD_DMEM, S_OUT_DMEM, S_RD_RF, S_OUT_RF, S_DONE
  } state_t;

  state_t             state, state_nxt;
  logic [IDX_W-1:0]   idx, idx_nxt;
  logic [DRAIN_W-1:0] drain_cnt, drain_nxt;
  logic [DATA_W:0]    count_inc;
  logic               halt_fetch, timeout_hit;

  logic               halt_req_nxt, dump_valid_nxt, dump_src_nxt, timed_out_nxt, done_nxt;
  logic [31:0]        dmem_rd_addr_nxt, dump_data_nxt, cycle_count_nxt;
  logic [4:0]         rf_rd_addr_nxt;
  logic [5:0]         dump_index_nxt;

  assign count_inc   = {1'b0, cycle_count} + (DATA_W + 1)'(1);
  assign halt_fetch  = (inst_from_imem == '0);
  assign timeout_hit = (count_inc == TIMEOUT_X);

  // State and registered outputs
  always_ff @(posedge clk) begin
    if (!reset) begin
      state        <= S_RUN;
      idx          <= '0;
      drain_cnt    <= '0;
      halt_req     <= 1'b0;
      dmem_rd_addr <= '0;
      rf_rd_addr   <= '0;
      dump_valid   <= 1'b0;
      dump_src     <= 1'b0;
      dump_index   <= '0;
      dump_data    <= '0;
      cycle_count  <= '0;
      timed_out    <= 1'b0;
      done         <= 1'b0;
    end else begin
      state        <= state_nxt;
      idx          <= idx_nxt;
      drain_cnt    <= drain_nxt;
      halt_req     <= halt_req_nxt;
      dmem_rd_addr <= dmem_rd_addr_nxt;
      rf_rd_addr   <= rf_rd_addr_nxt;
      dump_valid   <= dump_valid_nxt;
      dump_src     <= dump_src_nxt;
      dump_index   <= dump_index_nxt;
      dump_data    <= dump_data_nxt;
      cycle_count  <= cycle_count_nxt;
      timed_out    <= timed_out_nxt;
      done         <= done_nxt;
    end
  end

  // Next state; halt fetch wins over timeout in the same cycle
  always_comb begin
    state_nxt = state;
    case (state)
      S_RUN: begin
        if (halt_fetch)       state_nxt = S_DRAIN;
        else if (timeout_hit) state_nxt = S_RD_DMEM;
      end
      S_DRAIN:    if (drain_cnt == '0) state_nxt = S_RD_DMEM;
      S_RD_DMEM:  state_nxt = S_OUT_DMEM;
      S_OUT_DMEM: if (dump_ready) state_nxt = (idx == DMEM_LAST) ? S_RD_RF : S_RD_DMEM;
      S_RD_RF:    state_nxt = S_OUT_RF;
      S_OUT_RF:   if (dump_ready) state_nxt = (idx == RF_LAST) ? S_DONE : S_RD_RF;
      S_DONE:     state_nxt = S_DONE;
      default:    state_nxt = S_RUN;
    endcase
  end

  // Next values of the datapath and output registers
  always_comb begin
    idx_nxt          = idx;
    drain_nxt        = drain_cnt;
    halt_req_nxt     = halt_req;
    dmem_rd_addr_nxt = dmem_rd_addr;
    rf_rd_addr_nxt   = rf_rd_addr;
    dump_valid_nxt   = dump_valid;
    dump_src_nxt     = dump_src;
    dump_index_nxt   = dump_index;
    dump_data_nxt    = dump_data;
    cycle_count_nxt  = cycle_count;
    timed_out_nxt    = timed_out;
    done_nxt         = done;

    case (state)
      S_RUN: begin
        if (halt_fetch) begin
          drain_nxt = DRAIN_LD;
        end else begin
          cycle_count_nxt = (cycle_count == '1) ? cycle_count : count_inc[DATA_W-1:0];
          if (timeout_hit) timed_out_nxt = 1'b1;
        end
      end
      S_DRAIN: if (drain_cnt != '0) drain_nxt = drain_cnt - DRAIN_W'(1);
      S_RD_DMEM: begin
        dump_valid_nxt = 1'b1;
        dump_src_nxt   = 1'b0;
        dump_index_nxt = idx;
        dump_data_nxt  = dmem_rd_data;
      end
      S_OUT_DMEM: begin
        if (dump_ready) begin
          dump_valid_nxt = 1'b0;
          idx_nxt        = (idx == DMEM_LAST) ? '0 : idx + IDX_W'(1);
        end
      end
      S_RD_RF: begin
        dump_valid_nxt = 1'b1;
        dump_src_nxt   = 1'b1;
        dump_index_nxt = idx;
        dump_data_nxt  = rf_rd_data;
      end
      S_OUT_RF: begin
        if (dump_ready) begin
          dump_valid_nxt = 1'b0;
          idx_nxt        = (idx == RF_LAST) ? idx : idx + IDX_W'(1);
        end
      end
      default: ;
    endcase

    // Read addresses are launched on entry to the read state; data is sampled on the next edge
    if (state_nxt != S_RUN && state_nxt != S_DRAIN) halt_req_nxt = 1'b1;
    if (state_nxt == S_RD_DMEM) dmem_rd_addr_nxt = 32'(idx_nxt) << 2;
    if (state_nxt == S_RD_RF)   rf_rd_addr_nxt   = idx_nxt[RF_AW-1:0];
    if (state_nxt == S_DONE)    done_nxt         = 1'b1;
  end

endmodule
